// File: rtl/simple_uart_pkg.sv
// rtl/simple_uart_pkg.sv - shared types and constants for the simple_uart console peripheral
package simple_uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam logic [3:0] FRAME_BITS = 4'd10;
    localparam logic [3:0] GUARD_BITS = 4'd15;

    // Divisors below 2 would make the half-bit sample point zero cycles long.
    function automatic logic [31:0] bit_time(input logic [31:0] div);
        return (div < 32'd2) ? 32'd2 : div;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer for the asynchronous serial receive line
module uart_sync2 (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    // Both stages reset to mark so a line held idle never looks like a start bit.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/simple_uart.sv
// rtl/simple_uart.sv - memory-mapped 8N1 UART with programmable divisor and one-byte receive buffer
module simple_uart #(
    parameter logic [31:0] DEFAULT_DIV = 32'd1
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ser_tx,
    input  logic        ser_rx,
    input  logic [3:0]  reg_div_we,
    input  logic [31:0] reg_div_di,
    output logic [31:0] reg_div_do,
    input  logic        reg_dat_we,
    input  logic        reg_dat_re,
    input  logic [31:0] reg_dat_di,
    output logic [31:0] reg_dat_do,
    output logic        reg_dat_wait
);
    import simple_uart_pkg::*;

    logic [31:0] div_reg;
    logic [31:0] bit_t;
    logic [31:0] half_t;

    logic        tx_line;
    logic [8:0]  tx_shift;
    logic [3:0]  tx_bitcnt;
    logic [31:0] tx_divcnt;
    logic        tx_dummy;
    logic        tx_busy;
    logic        tx_bit_done;
    logic        div_write;

    logic        rx_s;
    rx_state_t   rx_state;
    rx_state_t   rx_next;
    logic [31:0] rx_cnt;
    logic [2:0]  rx_bitidx;
    logic [7:0]  rx_shift;
    logic [7:0]  rx_buf;
    logic        rx_valid;
    logic        half_done;
    logic        full_done;
    logic        rx_cnt_clr;
    logic        rx_bit_clr;
    logic        rx_shift_en;
    logic        rx_store;

    logic        unused_dat_hi;
    assign unused_dat_hi = ^reg_dat_di[31:8];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_reg <= DEFAULT_DIV;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (reg_div_we[i]) div_reg[8*i +: 8] <= reg_div_di[8*i +: 8];
            end
        end
    end

    assign reg_div_do = div_reg;
    assign bit_t      = bit_time(div_reg);
    assign half_t     = {1'b0, bit_t[31:1]};
    assign div_write  = |reg_div_we;

    // A divisor write in progress counts as busy so an idle-guard start never races a byte accept.
    assign tx_busy      = tx_dummy || div_write || (tx_bitcnt != 4'd0);
    assign reg_dat_wait = reg_dat_we && tx_busy;
    assign tx_bit_done  = tx_divcnt >= (bit_t - 32'd1);
    assign ser_tx       = tx_line;

    // The ">=" compare lets a shrinking divisor end the current bit at once instead of wrapping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tx_line   <= 1'b1;
            tx_shift  <= '1;
            tx_bitcnt <= 4'd0;
            tx_divcnt <= 32'd0;
            tx_dummy  <= 1'b1;
        end else if (tx_bitcnt == 4'd0) begin
            if (tx_dummy || div_write) begin
                tx_line   <= 1'b1;
                tx_shift  <= '1;
                tx_bitcnt <= GUARD_BITS;
                tx_divcnt <= 32'd0;
                tx_dummy  <= 1'b0;
            end else if (reg_dat_we) begin
                tx_line   <= 1'b0;
                tx_shift  <= {1'b1, reg_dat_di[7:0]};
                tx_bitcnt <= FRAME_BITS;
                tx_divcnt <= 32'd0;
            end
        end else begin
            if (div_write) tx_dummy <= 1'b1;
            if (tx_bit_done) begin
                tx_divcnt <= 32'd0;
                tx_bitcnt <= tx_bitcnt - 4'd1;
                tx_line   <= tx_shift[0];
                tx_shift  <= {1'b1, tx_shift[8:1]};
            end else begin
                tx_divcnt <= tx_divcnt + 32'd1;
            end
        end
    end

    uart_sync2 u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (ser_rx),
        .q      (rx_s)
    );

    assign half_done = rx_cnt >= (half_t - 32'd1);
    assign full_done = rx_cnt >= (bit_t - 32'd1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rx_state <= RX_IDLE;
        else         rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_s) rx_next = RX_START;
            RX_START: if (half_done) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_done && rx_bitidx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (full_done) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_cnt_clr  = 1'b0;
        rx_bit_clr  = 1'b0;
        rx_shift_en = 1'b0;
        rx_store    = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_clr = 1'b1;
                rx_bit_clr = 1'b1;
            end
            RX_START: rx_cnt_clr = half_done;
            RX_DATA: begin
                rx_cnt_clr  = full_done;
                rx_shift_en = full_done;
            end
            RX_STOP: begin
                rx_cnt_clr = full_done;
                rx_store   = full_done;
            end
            default: rx_cnt_clr = 1'b1;
        endcase
    end

    // Completion takes priority over a read strobe in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_cnt    <= 32'd0;
            rx_bitidx <= 3'd0;
            rx_shift  <= 8'd0;
            rx_buf    <= 8'd0;
            rx_valid  <= 1'b0;
        end else begin
            rx_cnt <= rx_cnt_clr ? 32'd0 : rx_cnt + 32'd1;
            if (rx_bit_clr) rx_bitidx <= 3'd0;
            if (rx_shift_en) begin
                rx_shift  <= {rx_s, rx_shift[7:1]};
                rx_bitidx <= rx_bitidx + 3'd1;
            end
            if (rx_store) begin
                rx_buf   <= rx_shift;
                rx_valid <= 1'b1;
            end else if (reg_dat_re) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign reg_dat_do = rx_valid ? {24'h000000, rx_buf} : 32'h00000000;

endmodule

// File: tb/tb_simple_uart.sv
// tb/tb_simple_uart.sv - self-checking bench for simple_uart against a bit-time arithmetic model
module tb_simple_uart;

    localparam logic [31:0] DEF_DIV = 32'd1;
    localparam int          BOUND   = 5000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        ser_tx;
    logic        ser_rx = 1'b1;
    logic [3:0]  reg_div_we = 4'h0;
    logic [31:0] reg_div_di = 32'h0;
    logic [31:0] reg_div_do;
    logic        reg_dat_we = 1'b0;
    logic        reg_dat_re = 1'b0;
    logic [31:0] reg_dat_di = 32'h0;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_div = DEF_DIV;

    simple_uart #(.DEFAULT_DIV(DEF_DIV)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ser_tx       (ser_tx),
        .ser_rx       (ser_rx),
        .reg_div_we   (reg_div_we),
        .reg_div_di   (reg_div_di),
        .reg_div_do   (reg_div_do),
        .reg_dat_we   (reg_dat_we),
        .reg_dat_re   (reg_dat_re),
        .reg_dat_di   (reg_dat_di),
        .reg_dat_do   (reg_dat_do),
        .reg_dat_wait (reg_dat_wait)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int eff_t(input logic [31:0] d);
        return (d < 32'd2) ? 2 : int'(d);
    endfunction

    // Ends at a negedge.
    task automatic write_div(input logic [3:0] we, input logic [31:0] di);
        @(posedge clk); #1;
        reg_div_we = we;
        reg_div_di = di;
        @(posedge clk); #1;
        reg_div_we = 4'h0;
        for (int i = 0; i < 4; i++) if (we[i]) model_div[8*i +: 8] = di[8*i +: 8];
        @(negedge clk);
        n_checks++;
        if (reg_div_do !== model_div) begin
            $display("FAIL div_readback: got %h expected %h", reg_div_do, model_div);
            n_fail++;
        end
    endtask

    // Called at a negedge; counts sampled cycles with wait high, returns after accept edge + 1.
    task automatic tx_request(input logic [7:0] d, output int waited, output int guard_bad);
        reg_dat_di = {24'h0, d};
        reg_dat_we = 1'b1;
        waited = 0;
        guard_bad = 0;
        #1;
        while (reg_dat_wait === 1'b1 && waited < BOUND) begin
            if (ser_tx !== 1'b1) guard_bad++;
            waited++;
            @(negedge clk); #1;
        end
        n_checks++;
        if (waited >= BOUND) begin
            $display("FAIL tx_accept_timeout: wait still %b after %0d cycles", reg_dat_wait, waited);
            n_fail++;
            reg_dat_we = 1'b0;
            waited = -1;
        end else begin
            @(posedge clk); #1;
            reg_dat_we = 1'b0;
        end
    endtask

    task automatic check_frame(input logic [7:0] d, input int t);
        logic [9:0] fr;
        logic       exp;
        fr = {1'b1, d, 1'b0};
        for (int k = 0; k < 12 * t; k++) begin
            @(negedge clk);
            exp = (k < 10 * t) ? fr[k / t] : 1'b1;
            n_checks++;
            if (ser_tx !== exp) begin
                $display("FAIL tx_bit byte=%h cycle=%0d: got %b expected %b", d, k, ser_tx, exp);
                n_fail++;
            end
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input int t, output int first_valid);
        logic [9:0] fr;
        fr = {1'b1, d, 1'b0};
        first_valid = -1;
        for (int c = 0; c < 12 * t; c++) begin
            @(posedge clk); #1;
            ser_rx = (c < 10 * t) ? fr[c / t] : 1'b1;
            @(negedge clk);
            if (first_valid < 0 && reg_dat_do != 32'h0) first_valid = c;
        end
    endtask

    task automatic read_pulse();
        @(posedge clk); #1;
        reg_dat_re = 1'b1;
        @(posedge clk); #1;
        reg_dat_re = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks += 4;
        if (ser_tx !== 1'b1) begin $display("FAIL reset_ser_tx: got %b expected 1", ser_tx); n_fail++; end
        if (reg_div_do !== DEF_DIV) begin $display("FAIL reset_div: got %h expected %h", reg_div_do, DEF_DIV); n_fail++; end
        if (reg_dat_do !== 32'h0) begin $display("FAIL reset_dat_do: got %h expected 0", reg_dat_do); n_fail++; end
        if (reg_dat_wait !== 1'b0) begin $display("FAIL reset_wait: got %b expected 0", reg_dat_wait); n_fail++; end
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_guard();
        int w, bad;
        write_div(4'hF, 32'd16);
        tx_request(8'h55, w, bad);
        n_checks += 2;
        if (w !== 15 * 16) begin $display("FAIL guard_wait_cycles: got %0d expected %0d", w, 15 * 16); n_fail++; end
        if (bad !== 0) begin $display("FAIL guard_line_mark: %0d cycles low expected 0", bad); n_fail++; end
        check_frame(8'h55, 16);
    endtask

    task automatic test_tx_pattern();
        int w, bad;
        @(negedge clk);
        tx_request(8'hA5, w, bad);
        n_checks++;
        if (w !== 0) begin $display("FAIL idle_accept_wait: got %0d expected 0", w); n_fail++; end
        check_frame(8'hA5, 16);
    endtask

    task automatic test_byte_lane();
        write_div(4'b0010, 32'h0000AB00);
        n_checks++;
        if (reg_div_do !== 32'h0000AB10) begin
            $display("FAIL byte_lane: got %h expected 0000ab10", reg_div_do);
            n_fail++;
        end
        write_div(4'hF, 32'd16);
    endtask

    task automatic test_rx();
        int fv;
        read_pulse();
        send_rx(8'hA3, 16, fv);
        n_checks += 3;
        if (reg_dat_do !== 32'h000000A3) begin $display("FAIL rx_data: got %h expected 000000a3", reg_dat_do); n_fail++; end
        if (fv < 152 || fv > 157) begin $display("FAIL rx_latency: got %0d expected 152..157", fv); n_fail++; end
        read_pulse();
        if (reg_dat_do !== 32'h0) begin $display("FAIL rx_read_clear: got %h expected 0", reg_dat_do); n_fail++; end
    endtask

    task automatic test_glitch();
        int fv;
        @(posedge clk); #1;
        ser_rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        ser_rx = 1'b1;
        repeat (12 * 16) @(negedge clk);
        n_checks += 2;
        if (reg_dat_do !== 32'h0) begin $display("FAIL glitch_ignored: got %h expected 0", reg_dat_do); n_fail++; end
        send_rx(8'h3C, 16, fv);
        if (reg_dat_do !== 32'h0000003C) begin $display("FAIL glitch_recover: got %h expected 0000003c", reg_dat_do); n_fail++; end
        read_pulse();
    endtask

    task automatic test_overrun();
        int fv;
        send_rx(8'h41, 16, fv);
        send_rx(8'h42, 16, fv);
        n_checks++;
        if (reg_dat_do !== 32'h00000042) begin $display("FAIL overrun: got %h expected 00000042", reg_dat_do); n_fail++; end
        read_pulse();
    endtask

    task automatic test_random_tx();
        logic [31:0] dv;
        logic [7:0]  d;
        int          w, bad;
        for (int it = 0; it < 4; it++) begin
            dv = (it == 0) ? 32'd0 : (it == 1) ? 32'd1 : 32'($urandom_range(2, 12));
            d  = 8'($urandom);
            write_div(4'hF, dv);
            tx_request(d, w, bad);
            n_checks++;
            if (w !== 15 * eff_t(dv)) begin
                $display("FAIL rand_guard div=%0d: got %0d expected %0d", dv, w, 15 * eff_t(dv));
                n_fail++;
            end
            check_frame(d, eff_t(dv));
        end
    endtask

    task automatic test_random_rx();
        logic [31:0] dv;
        logic [7:0]  d;
        int          fv;
        for (int it = 0; it < 5; it++) begin
            dv = 32'($urandom_range(8, 24));
            d  = 8'($urandom_range(1, 255));
            write_div(4'hF, dv);
            send_rx(d, eff_t(dv), fv);
            n_checks += 2;
            if (reg_dat_do !== {24'h0, d}) begin
                $display("FAIL rand_rx div=%0d: got %h expected %h", dv, reg_dat_do, {24'h0, d});
                n_fail++;
            end
            read_pulse();
            if (reg_dat_do !== 32'h0) begin $display("FAIL rand_rx_clear: got %h expected 0", reg_dat_do); n_fail++; end
        end
    endtask

    task automatic test_mid_reset();
        int w, bad;
        write_div(4'hF, 32'd16);
        tx_request(8'h00, w, bad);
        repeat (50) @(negedge clk);
        n_checks += 4;
        if (ser_tx !== 1'b0) begin $display("FAIL mid_frame_low: got %b expected 0", ser_tx); n_fail++; end
        #2;
        resetn = 1'b0;
        #1;
        if (ser_tx !== 1'b1) begin $display("FAIL mid_reset_tx: got %b expected 1", ser_tx); n_fail++; end
        if (reg_div_do !== DEF_DIV) begin $display("FAIL mid_reset_div: got %h expected %h", reg_div_do, DEF_DIV); n_fail++; end
        if (reg_dat_do !== 32'h0) begin $display("FAIL mid_reset_dat: got %h expected 0", reg_dat_do); n_fail++; end
        model_div = DEF_DIV;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_guard();
        test_tx_pattern();
        test_byte_lane();
        test_rx();
        test_glitch();
        test_overrun();
        test_random_tx();
        test_random_rx();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
